// File: rtl/dac_stream_ctrl_pkg.sv
// Shared types for the DAC streamer: FSM encoding and the zero-level (midscale) code.
package dac_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int MS_MAX_W = 32;

  // Code for a zero sample; also the XOR mask that turns two's complement into offset binary.
  function automatic logic [MS_MAX_W-1:0] midscale(input int unsigned data_w, input logic fmt_ob);
    midscale = '0;
    if (fmt_ob) midscale[data_w-1] = 1'b1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty; flush wins over push/pop.
module dac_sample_fifo #(
  parameter int WIDTH = 20,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;

  assign level   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push+pop while full is accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// Multi-channel DAC streamer: power-up sequencing, sample FIFO, DCLKIO divider,
// output encoding and hold-last underflow handling.
module dac_stream_ctrl
  import dac_stream_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 10,
  parameter int FIFO_AW   = 4,
  parameter int DIV_W     = 8,
  parameter int WAKE_CYC  = 100,
  parameter int PRIME_LVL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     fmt_ob,
  input  logic [DIV_W-1:0]         div,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NUM_CH*DATA_W-1:0] dac_data,
  output logic                     dac_dclkio,
  output logic                     dac_pwrdn,
  output logic [15:0]              underflow_cnt,
  output logic                     busy
);
  localparam int WORD_W = NUM_CH * DATA_W;
  localparam int WK_W   = $clog2(WAKE_CYC + 1);
  localparam logic [MS_MAX_W-1:0] MS_RST = midscale(DATA_W, 1'b1);
  localparam logic [WORD_W-1:0] DATA_RST = {NUM_CH{MS_RST[DATA_W-1:0]}};

  state_e state_q, state_d;
  logic [WK_W-1:0]   wake_q, wake_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, per_q, per_d, div_eff;
  logic              dclk_q, dclk_d, pwrdn_q, pwrdn_d;
  logic [WORD_W-1:0] data_q, data_d, fifo_dout, ms_word, enc_word;
  logic [15:0]       uf_q, uf_d;
  logic [MS_MAX_W-1:0] ms_full;
  logic [FIFO_AW:0]  level;
  logic fifo_full, fifo_empty, push, load, flush;

  assign ms_full = midscale(DATA_W, fmt_ob);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ms_word[c*DATA_W +: DATA_W] = ms_full[DATA_W-1:0];
  end
  assign enc_word = fifo_dout ^ ms_word;
  assign div_eff  = (div == '0) ? DIV_W'(1) : div;

  assign s_ready       = !fifo_full && (state_q != ST_OFF);
  assign push          = s_valid && s_ready;
  assign busy          = (state_q == ST_RUN);
  assign dac_data      = data_q;
  assign dac_dclkio    = dclk_q;
  assign dac_pwrdn     = pwrdn_q;
  assign underflow_cnt = uf_q;

  dac_sample_fifo #(.WIDTH(WORD_W), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .flush (flush),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    data_d  = data_q;
    uf_d    = uf_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_OFF: begin
        flush = 1'b1;
        if (enable) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_q == WK_W'(WAKE_CYC - 1)) state_d = ST_PRIME;
        else                               wake_d  = wake_q + WK_W'(1);
      end
      ST_PRIME: begin
        if (level >= (FIFO_AW+1)'(PRIME_LVL) || fifo_full) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q >= per_q) load  = 1'b1;
        else                cnt_d = cnt_q + DIV_W'(1);
      end
      default: state_d = ST_OFF;
    endcase
    // The period length is latched only at load points so a div change never cuts a period short.
    if (load) begin
      cnt_d = '0;
      per_d = div_eff;
      if (!fifo_empty)          data_d = enc_word;
      else if (uf_q != 16'hFFFF) uf_d  = uf_q + 16'd1;
    end
    if (!enable) begin
      state_d = ST_OFF;
      flush   = 1'b1;
      load    = 1'b0;
      wake_d  = '0;
      cnt_d   = '0;
      uf_d    = '0;
    end
    if (state_d == ST_OFF) data_d = ms_word;
    pwrdn_d = (state_d == ST_OFF);
    dclk_d  = (state_d == ST_RUN) && (cnt_d > (per_d >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      wake_q  <= '0;
      cnt_q   <= '0;
      per_q   <= DIV_W'(1);
      dclk_q  <= 1'b0;
      pwrdn_q <= 1'b1;
      data_q  <= DATA_RST;
      uf_q    <= '0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      dclk_q  <= dclk_d;
      pwrdn_q <= pwrdn_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Randomized scoreboard bench for dac_stream_ctrl with a cycle-level reference model.
module tb_dac_stream_ctrl;
  localparam int NUM_CH = 2, DATA_W = 10, FIFO_AW = 4, DIV_W = 8;
  localparam int WAKE_CYC = 100, PRIME_LVL = 4, DEPTH = 16;
  localparam int W = NUM_CH * DATA_W;
  localparam logic [W-1:0] MS = 20'h80200;

  logic clk, rst, enable, fmt_ob, s_valid, s_ready, dac_dclkio, dac_pwrdn, busy;
  logic [DIV_W-1:0] div;
  logic [W-1:0] s_data, dac_data;
  logic [15:0] underflow_cnt;

  int n_chk = 0, n_err = 0;
  logic [W-1:0] sb[$];
  int m_en_cyc, m_k, m_dlat, m_uf;
  bit m_run, m_ld;
  logic [W-1:0] m_data;
  logic [DIV_W-1:0] divs [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd9};

  dac_stream_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W),
                    .WAKE_CYC(WAKE_CYC), .PRIME_LVL(PRIME_LVL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fmt_ob(fmt_ob), .div(div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_data(dac_data),
    .dac_dclkio(dac_dclkio), .dac_pwrdn(dac_pwrdn), .underflow_cnt(underflow_cnt), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] ms_of(input logic f);
    return f ? MS : '0;
  endfunction

  function automatic logic [W-1:0] enc(input logic [W-1:0] w, input logic f);
    return w ^ ms_of(f);
  endfunction

  // Reference model: advances at each edge from pre-edge inputs, then checks every output.
  initial begin
    m_en_cyc = 0; m_k = 0; m_dlat = 1; m_uf = 0; m_run = 0; m_data = MS; m_ld = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        m_run = 0; m_en_cyc = 0; m_k = 0; m_uf = 0; m_data = MS; sb.delete();
      end else if (!enable) begin
        m_run = 0; m_en_cyc = 0; m_k = 0; m_uf = 0; m_data = ms_of(fmt_ob); sb.delete();
      end else begin
        m_ld = 0;
        if (m_run) begin
          m_k++;
          if (m_k > m_dlat) m_ld = 1;
        end else if (m_en_cyc > WAKE_CYC && sb.size() >= PRIME_LVL) begin
          m_run = 1;
          m_ld  = 1;
        end
        if (m_ld) begin
          if (sb.size() > 0) m_data = enc(sb.pop_front(), fmt_ob);
          else if (m_uf < 65535) m_uf++;
          m_k = 0;
          m_dlat = (div == 0) ? 1 : int'(div);
        end
        m_en_cyc++;
      end
      #2;
      chk("busy", 32'(busy), 32'(m_run));
      chk("pwrdn", 32'(dac_pwrdn), 32'(m_en_cyc == 0));
      chk("s_ready", 32'(s_ready), 32'(m_en_cyc > 0 && sb.size() < DEPTH));
      chk("dac_data", 32'(dac_data), 32'(m_data));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
      chk("dclkio", 32'(dac_dclkio), 32'(m_run && (m_k > (m_dlat >> 1))));
    end
  end

  // One clock of stimulus; accepted words go to the scoreboard after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] w);
    logic rdy, en;
    @(negedge clk);
    s_valid = v;
    s_data  = w;
    rdy = s_ready;
    en  = enable;
    @(posedge clk); #2;
    if (v && rdy && en) sb.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle(0, '0);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic rand_phase(input int n, input bit vary_fmt);
    for (int i = 0; i < n; i++) begin
      if (vary_fmt && $urandom_range(0, 15) == 0) fmt_ob = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) div = divs[$urandom_range(0, 5)];
      cycle($urandom_range(0, 2) != 0, 20'($urandom));
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; fmt_ob = 1'b1; div = 8'd3; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_pwrdn", 32'(dac_pwrdn), 32'd1);
    chk("rst_data", 32'(dac_data), 32'(MS));
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_dclkio", 32'(dac_dclkio), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) cycle(0, '0);

    // Power-up with a primed FIFO, then steady streaming at div=3.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 20'($urandom));
    repeat (140) cycle(0, '0);
    rand_phase(200, 1'b0);

    // Random format and period changes.
    rand_phase(600, 1'b1);

    // Encoding of 0x1FF in both formats.
    fmt_ob = 1'b1; div = 8'd3;
    wait_drain(400);
    cycle(1, 20'h7FDFF);
    wait_drain(20);
    chk("enc_ob", 32'(dac_data), 32'h000FFFFF);
    fmt_ob = 1'b0;
    cycle(1, 20'h7FDFF);
    wait_drain(20);
    chk("enc_2c", 32'(dac_data), 32'h0007FDFF);

    // Underflow: hold-last and one count per period.
    fmt_ob = 1'b1;
    repeat (60) cycle(0, '0);
    chk("uf_busy", 32'(busy), 32'd1);

    // Fill to full with a long period, then push+pop while full.
    div = 8'd255;
    for (int i = 0; i < 20; i++) cycle(1, 20'($urandom));
    chk("full_ready", 32'(s_ready), 32'd0);
    div = 8'd3;
    for (int i = 0; i < 300; i++) cycle(1, 20'($urandom));

    // Drop enable mid-RUN.
    enable = 1'b0;
    cycle(0, '0);
    chk("off_pwrdn", 32'(dac_pwrdn), 32'd1);
    chk("off_data", 32'(dac_data), 32'(MS));
    chk("off_uf", 32'(underflow_cnt), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    repeat (3) cycle(0, '0);

    // Re-run, underflow, then async reset mid-period.
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1, 20'($urandom));
    repeat (160) cycle(0, '0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_pwrdn", 32'(dac_pwrdn), 32'd1);
    chk("arst_data", 32'(dac_data), 32'(MS));
    chk("arst_dclkio", 32'(dac_dclkio), 32'd0);
    chk("arst_uf", 32'(underflow_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    repeat (3) cycle(0, '0);
    rst = 1'b1;
    repeat (5) cycle(0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
